// File: rtl/sweep_ctrl_if.sv
// sweep_ctrl_if
//   Bundles the command inputs and the sweep outputs of sweep_ctrl.
//   Command pulses (start, stop, step) are single-cycle strobes sampled
//   on the rising clock edge. There is no back-pressure: a pulse is either
//   acted on in the cycle it is seen or dropped, and it is never queued.
//   Priority within one cycle is stop > start > step.
//
//   Signals
//     start  : run / resume pulse
//     stop   : pause pulse, or clear to idle when already paused
//     step   : single advance pulse, honoured only while paused
//     speed  : 2-bit speed select, period = TICK_DIV >> speed
//     Q      : sweep value
//     dir    : 1 = counting up, 0 = counting down
//     tick   : one-cycle strobe when Q shows a new value
//     blink  : 50% duty run indicator
//     state  : controller state (0 idle, 1 run, 2 pause)
//
//   Modports
//     slave  : the controller (consumes commands, drives outputs)
//     master : the board side (drives commands, observes outputs)
interface sweep_ctrl_if;
    logic       start;
    logic       stop;
    logic       step;
    logic [1:0] speed;
    logic [2:0] Q;
    logic       dir;
    logic       tick;
    logic       blink;
    logic [1:0] state;

    modport slave (
        input  start, stop, step, speed,
        output Q, dir, tick, blink, state
    );

    modport master (
        output start, stop, step, speed,
        input  Q, dir, tick, blink, state
    );
endinterface

// File: rtl/sweep_ctrl.sv
// sweep_ctrl
//   Run controller for a 3-bit ping-pong LED sweep. Divides the clock to
//   produce the sweep advance, sequences idle / run / pause, and applies a
//   2-bit speed select and single-step control.
//
//   Ports
//     clk  : system clock, rising edge
//     rst  : synchronous active-high reset
//     bus  : sweep_ctrl_if.slave (commands in, sweep outputs out)
//
//   Parameters
//     TICK_DIV : cycles per sweep step at speed 0, multiple of 8 and >= 8
//     MAX_VAL  : top value of the sweep (bottom is 0)
//
//   All outputs come straight from registers.
module sweep_ctrl #(
    parameter logic [31:0] TICK_DIV = 32'd50000000,
    parameter logic [2:0]  MAX_VAL  = 3'd7
) (
    input  logic        clk,
    input  logic        rst,
    sweep_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  q_q, q_d, adv_q;
    logic        dir_q, dir_d, adv_dir;
    logic        tick_q, tick_d;
    logic        blink_q, blink_d;
    logic [31:0] div_q, div_d;
    logic [31:0] period, term, half;

    // Speed is applied live; a faster speed mid-period fires at once because
    // the terminal compare is >= rather than ==.
    assign period = TICK_DIV >> bus.speed;
    assign term   = period - 32'd1;
    assign half   = period >> 1;

    // Next sweep position, bouncing at 0 and MAX_VAL without repeating the end.
    always_comb begin
        adv_q   = q_q;
        adv_dir = dir_q;
        if (dir_q) begin
            if (q_q < MAX_VAL) begin
                adv_q = q_q + 3'd1;
            end else begin
                adv_q   = q_q - 3'd1;
                adv_dir = 1'b0;
            end
        end else begin
            if (q_q != 3'd0) begin
                adv_q = q_q - 3'd1;
            end else begin
                adv_q   = q_q + 3'd1;
                adv_dir = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        dir_d   = dir_q;
        div_d   = div_q;
        tick_d  = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.stop) begin
                    // Stop outranks a tick due in the same cycle.
                    state_d = PAUSE;
                end else if (div_q >= term) begin
                    div_d  = 32'd0;
                    q_d    = adv_q;
                    dir_d  = adv_dir;
                    tick_d = 1'b1;
                end else begin
                    div_d = div_q + 32'd1;
                end
            end
            PAUSE: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    q_d     = 3'd0;
                    dir_d   = 1'b1;
                    div_d   = 32'd0;
                end else if (bus.start) begin
                    // div_cnt resumes from where it froze.
                    state_d = RUN;
                end else if (bus.step) begin
                    q_d    = adv_q;
                    dir_d  = adv_dir;
                    tick_d = 1'b1;
                end
            end
            default: begin
                // IDLE, and the unused encoding which behaves as IDLE.
                state_d = IDLE;
                q_d     = 3'd0;
                dir_d   = 1'b1;
                div_d   = 32'd0;
                if (bus.start) begin
                    state_d = RUN;
                end
            end
        endcase
        // Registered alongside div_cnt so it lines up with the new count.
        blink_d = (state_d == RUN) && (div_d >= half);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= 3'd0;
            dir_q   <= 1'b1;
            div_q   <= 32'd0;
            tick_q  <= 1'b0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            dir_q   <= dir_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            blink_q <= blink_d;
        end
    end

    assign bus.Q     = q_q;
    assign bus.dir   = dir_q;
    assign bus.tick  = tick_q;
    assign bus.blink = blink_q;
    assign bus.state = state_q;

endmodule
